// File: rtl/ook_frame_decoder_if.sv
// ook_frame_decoder_if: OOK line input and decoded-frame outputs of the frame decoder.
interface ook_frame_decoder_if #(
    parameter int PACKET_BITS = 40
);
    logic                   ook_in;
    logic [PACKET_BITS-1:0] packet_data;
    logic                   packet_valid;
    logic                   frame_error;
    logic                   busy;

    modport master (input ook_in, output packet_data, packet_valid, frame_error, busy);
    modport slave  (output ook_in, input packet_data, packet_valid, frame_error, busy);
endinterface

// File: rtl/ook_frame_decoder.sv
// ook_frame_decoder: measures OOK pulse widths, decodes PWM bits into a fixed-length frame.
// Optional deglitch stage enabled by OOK_DECODER_GLITCH_FILTER_EN.
module ook_frame_decoder #(
    parameter int UNIT_CYCLES = 4000,
    parameter int TOL_CYCLES  = 1000,
    parameter int PACKET_BITS = 40
) (
    input logic clk,
    input logic reset_n,
    ook_frame_decoder_if.master bus
);
    localparam int CW = $clog2(8 * UNIT_CYCLES + 1);
    localparam int BW = $clog2(PACKET_BITS + 1);
    localparam logic [CW-1:0] GAP_W  = CW'(8 * UNIT_CYCLES);
    localparam logic [CW-1:0] END_W  = CW'(4 * UNIT_CYCLES);
    localparam logic [CW-1:0] ONE_LO = CW'(UNIT_CYCLES - TOL_CYCLES);
    localparam logic [CW-1:0] ONE_HI = CW'(UNIT_CYCLES + TOL_CYCLES);
    localparam logic [CW-1:0] TWO_LO = CW'(2 * UNIT_CYCLES - TOL_CYCLES);
    localparam logic [CW-1:0] TWO_HI = CW'(2 * UNIT_CYCLES + TOL_CYCLES);
    localparam logic [BW-1:0] FULL   = BW'(PACKET_BITS);

    typedef enum logic [2:0] {IDLE, ARMED, SYNC, LOW, HIGH} state_t;

    state_t                 state;
    logic                   s1, s2, s, s_prev, edge_s, one_u, two_u, err, done;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_cnt;
    logic [PACKET_BITS-1:0] shift;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) {s2, s1} <= 2'b00;
        else {s2, s1} <= {s1, bus.ook_in};

`ifdef OOK_DECODER_GLITCH_FILTER_EN
    logic [1:0] hist;
    // s1 is the newest of the four agreeing samples, so the filter adds exactly 3 cycles
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            hist <= 2'b00;
            s    <= 1'b0;
        end else begin
            hist <= {hist[0], s2};
            if ({s1, s2, hist} == 4'b1111 || {s1, s2, hist} == 4'b0000) s <= s2;
        end
`else
    assign s = s2;
`endif

    assign edge_s = s != s_prev;
    assign one_u  = cnt >= ONE_LO && cnt <= ONE_HI;
    assign two_u  = cnt >= TWO_LO && cnt <= TWO_HI;
    assign done   = state == LOW && !edge_s && cnt == END_W && bit_cnt == FULL;

    always_comb
        err = state == SYNC ? edge_s && !one_u :
              state == LOW  ? (edge_s ? !(one_u || two_u) : cnt == END_W && bit_cnt != FULL) :
              state == HIGH ? (edge_s ? !(one_u || two_u) || bit_cnt == FULL : cnt > TWO_HI) :
              1'b0;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state            <= IDLE;
            s_prev           <= 1'b0;
            cnt              <= '0;
            bit_cnt          <= '0;
            shift            <= '0;
            bus.packet_data  <= '0;
            bus.packet_valid <= 1'b0;
            bus.frame_error  <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            s_prev           <= s;
            cnt              <= edge_s ? CW'(1) : cnt == GAP_W ? cnt : cnt + 1'b1;
            bus.packet_valid <= done;
            bus.frame_error  <= err;
            if (err) begin
                state    <= IDLE;
                shift    <= '0;
                bit_cnt  <= '0;
                bus.busy <= 1'b0;
            end else if (done) begin
                state           <= ARMED;
                bus.packet_data <= shift;
                bus.busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE:  if (!s && cnt == GAP_W) state <= ARMED;
                    ARMED: if (edge_s && s) begin
                        state    <= SYNC;
                        bus.busy <= 1'b1;
                    end
                    SYNC:  if (edge_s) begin
                        state   <= LOW;
                        bit_cnt <= '0;
                        shift   <= '0;
                    end
                    LOW:   if (edge_s) state <= HIGH;
                    HIGH:  if (edge_s) begin
                        state   <= LOW;
                        shift   <= (shift << 1) | PACKET_BITS'(two_u);
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
endmodule
